mealy_seq_detector_param: RTL
=============================

// Module: mealy_seq_detector_param
// PURPOSE
//   Parametrised Mealy serial-pattern detector: next-generation replacement of the fixed 2-bit-state
//   next-state logic. One bit of w is consumed per valid cycle. z flags completion of PATTERN on the
//   same cycle as its last bit. Includes state register, overlap mode, valid qualifier and a match counter.
//   Sits between the serial bit source and the match-consuming logic in the FSM lab designs.
// PARAMETERS
//   N        3        pattern length in bits, 2..16
//   PATTERN  3'b101   target sequence; PATTERN[N-1] is the first bit received
//   OVERLAP  1        1: a match's suffix may start the next match; 0: restart from empty after a match
//   CNT_W    8        match_count width
// PORTS
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous, active-high reset
//   w            in   1        serial data bit
//   w_valid      in   1        w is consumed this cycle when 1
//   z            out  1        match strobe (Mealy, see BEHAVIOUR)
//   y            out  SW       current state = matched-prefix length 0..N-1, SW = max(1,$clog2(N))
//   match_count  out  CNT_W    number of matches since reset, saturating
// BEHAVIOUR
//   - The clock is clk. The reset is reset, synchronous and active-high. All state updates occur on
//     the rising edge of clk.
//   - Reset values: y=0, match_count=0. z=0 in every cycle where reset=1, regardless of w or w_valid.
//   - State k = length of the longest suffix of consumed bits that equals a prefix of PATTERN, with k<N.
//   - Expected bit in state k is e_k = PATTERN[N-1-k].
//   - Valid cycle, w==e_k and k<N-1: next y=k+1, z=0.
//   - Valid cycle, w==e_k and k==N-1: z=1 combinationally in this cycle.
//       next y = f(N) when OVERLAP=1, where f is the KMP failure function of PATTERN.
//       next y = 0 when OVERLAP=0.
//   - Valid cycle, w!=e_k: next y = longest prefix of PATTERN that is a suffix of (matched prefix, w)
//     (KMP fallback). z=0.
//   - The full N x 2 next-state table is computed at elaboration. No runtime cost beyond a table lookup.
//   - w_valid=0: y and match_count hold, z=0. Bit gaps do not break a partial match.
//   - z = w_valid & (y==N-1) & (w==e_{N-1}) & ~reset. This is a pure combinational path from w to z.
//   - match_count increments by 1 on each cycle where z=1.
//   - match_count saturates at 2^CNT_W-1 and never wraps.
//   - reset during a partial match: next cycle y=0. A match in progress is lost and is not counted.
//   - reset has priority over w_valid in the same cycle.
//   - Latency: 0 cycles from the last pattern bit to z (non-registered build).
// CONFIGURATION
//   MEALY_ZREG_EN defined:
//     - z is driven by a flop loaded with the combinational strobe.
//     - z asserts exactly 1 cycle after the last pattern bit is sampled. This breaks the w->z path.
//     - The z flop resets to 0.
//     - match_count timing is unchanged: it still updates on the edge that consumes the last bit.
//   MEALY_ZREG_EN undefined:
//     - z is combinational as described in BEHAVIOUR.
//   y and match_count behave identically in both builds.
// TESTING
//   1. N=3, PATTERN=101, OVERLAP=1. w=1,0,1,0,1 on consecutive valid cycles -> z=1 on bits 3 and 5;
//      match_count=2; final y=1.
//   2. Same stream with OVERLAP=0 -> z=1 only on bit 3; match_count=1; final y=1.
//   3. PATTERN=110. w=1,1,1,0 -> y sequence 1,2,2,0; z=1 on bit 4 only (fallback holds y=2 on the 3rd 1).
//   4. PATTERN=101. w=1,0, then reset=1 for 1 cycle, then w=1 -> z=0 throughout; y=1 after the last bit;
//      match_count=0.
//   5. PATTERN=101. w=1, then w_valid=0 for 3 cycles with w toggling, then w=0,1 -> z=0 during the gap;
//      z=1 on the final bit.
//   6. CNT_W=2. Five overlapping matches -> match_count goes 1,2,3,3,3.
//      Rerun with MEALY_ZREG_EN -> each z pulse is delayed by exactly 1 cycle.

Source files
------------

// File: rtl/mealy_seq_detector_param.sv
// -----------------------------------------------------------------------------
// mealy_seq_detector_param
//
// Purpose
//   Parametrised Mealy serial-pattern detector. It consumes one bit of w on
//   every cycle where w_valid is high. It raises z on the cycle that completes
//   PATTERN and keeps a saturating count of matches. The state is the length of
//   the prefix matched so far (0..N-1). The N x 2 next-state table is built at
//   elaboration with KMP fallback semantics, so the runtime cost is a single
//   table lookup.
//
// Parameters
//   N        pattern length in bits (2..16)
//   PATTERN  target sequence; PATTERN[N-1] is the first bit received
//   OVERLAP  1: a match's suffix may start the next match
//            0: restart from an empty history after a match
//   CNT_W    match_count width
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   w            in   1      serial data bit
//   w_valid      in   1      w is consumed this cycle when 1
//   z            out  1      match strobe
//   y            out  SW     current state (matched-prefix length), SW = max(1,$clog2(N))
//   match_count  out  CNT_W  number of matches since reset, saturating
//
// Handshake
//   w_valid is a qualifier only; the detector has no ready because it always
//   accepts. A bit is consumed exactly on a rising edge where w_valid=1 and
//   reset=0. When w_valid=0 the state and count hold, so gaps between bits
//   do not break a partial match.
//
// Build option
//   MEALY_ZREG_EN : when defined, z comes from a flop that is loaded with the
//                   combinational strobe. z then appears one cycle after the
//                   last pattern bit, and the w->z combinational path is gone.
//                   match_count still updates on the edge that consumes the
//                   last bit.
// -----------------------------------------------------------------------------
module mealy_seq_detector_param #(
  parameter int           N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b101,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8,
  localparam int          SW      = (N > 2) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic             w_valid,
  output logic             z,
  output logic [SW-1:0]    y,
  output logic [CNT_W-1:0] match_count
);

  // Next state from state k on input bit b. Form the string s = (first k
  // pattern bits, b). The result is the longest proper prefix of PATTERN
  // (length < N) that is also a suffix of s. A completed match therefore lands
  // on the KMP failure value f(N). In non-overlap mode it is forced to 0.
  function automatic logic [SW-1:0] next_of(input int k, input logic b);
    logic [16:0] s;
    int          best;
    int          max_l;
    bit          ok;
    s    = '0;
    best = 0;
    for (int i = 0; i < k; i++) s[i] = PATTERN[N-1-i];
    s[k]  = b;
    max_l = (k + 1 < N - 1) ? k + 1 : N - 1;
    for (int l = 1; l <= max_l; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++)
        if (s[k+1-l+j] != PATTERN[N-1-j]) ok = 1'b0;
      if (ok) best = l;
    end
    if ((k == N - 1) && (b == PATTERN[0]) && !OVERLAP) best = 0;
    return SW'(best);
  endfunction

  // Flattened table; entry index = 2*k + b, each entry SW bits wide.
  function automatic logic [2*N*SW-1:0] build_tbl();
    logic [2*N*SW-1:0] t;
    t = '0;
    for (int k = 0; k < N; k++) begin
      t[(2*k)*SW   +: SW] = next_of(k, 1'b0);
      t[(2*k+1)*SW +: SW] = next_of(k, 1'b1);
    end
    return t;
  endfunction

  localparam logic [2*N*SW-1:0] NEXT_TBL = build_tbl();
  localparam logic [SW-1:0]     LAST_ST  = SW'(N - 1);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_next;
  logic [SW:0]   tbl_idx;
  logic          z_comb;

  assign tbl_idx = {state_q, w};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= '0;
    else       state_q <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: table lookup on a valid bit, hold otherwise. Encodings
  // at or above N cannot be reached. They fall back to 0 so that the lookup
  // never indexes past the end of the table.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_q;
    if (w_valid) begin
      if (state_q <= LAST_ST) state_next = NEXT_TBL[int'(tbl_idx)*SW +: SW];
      else                    state_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: Mealy strobe on the bit that completes the pattern. reset
  // masks the strobe, so a match cut short by reset is never flagged or counted.
  // ---------------------------------------------------------------------------
  always_comb begin
    z_comb = w_valid & (state_q == LAST_ST) & (w == PATTERN[0]) & ~reset;
  end

  assign y = state_q;

  // Saturating match counter; it advances on the edge that consumes the last bit.
  always_ff @(posedge clk) begin
    if (reset)
      match_count <= '0;
    else if (z_comb && (match_count != {CNT_W{1'b1}}))
      match_count <= match_count + CNT_W'(1);
  end

`ifdef MEALY_ZREG_EN
  logic z_q;

  always_ff @(posedge clk) begin
    if (reset) z_q <= 1'b0;
    else       z_q <= z_comb;
  end

  assign z = z_q;
`else
  assign z = z_comb;
`endif

endmodule
